// File: rtl/wt_dcache_port_sched_pkg.sv
// Shared types for the write-through dcache port scheduler: FSM states, port selection
// and the request payload presented to the dcache.
package wt_dcache_port_sched_pkg;

    localparam int WT_ADDR_W = 32;
    localparam int WT_DATA_W = 32;
    localparam int WT_BE_W   = WT_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB,
        DRAIN_NI,
        DRAIN_FENCE,
        FENCE_WAIT
    } sched_state_e;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LD,
        SEL_ST
    } port_sel_e;

    typedef struct packed {
        logic                 we;
        logic [WT_ADDR_W-1:0] addr;
        logic [WT_DATA_W-1:0] wdata;
        logic [WT_BE_W-1:0]   be;
    } mem_port_req_t;

endpackage

// File: rtl/wt_store_credit_cnt.sv
// Outstanding-store credit counter: +1 per store grant, -1 per write-ack,
// with limit/zero flags and a sticky flag for an ack arriving with nothing outstanding.
module wt_store_credit_cnt #(
    parameter int MAX_CNT = 7,
    parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             at_limit,
    output logic             is_zero,
    output logic             underflow_err
);

    // A simultaneous grant and ack cancel out; an unpaired ack at zero is an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            underflow_err <= 1'b0;
        end else if (inc && !dec) begin
            count <= count + 1'b1;
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - 1'b1;
            end else begin
                underflow_err <= 1'b1;
            end
        end
    end

    assign at_limit = (count == CNT_W'(MAX_CNT));
    assign is_zero  = (count == '0);

endmodule

// File: rtl/wt_dcache_port_sched.sv
// Arbitrates the single write-through dcache port between the load unit and the store
// write buffer, enforcing store credits, non-idempotent load ordering and fence draining.
module wt_dcache_port_sched
    import wt_dcache_port_sched_pkg::*;
#(
    parameter int  ADDR_W         = WT_ADDR_W,
    parameter int  DATA_W         = WT_DATA_W,
    parameter int  MAX_OUT_STORES = 7,
    parameter int  STARVE_LIMIT   = 4,
    localparam int BE_W           = DATA_W / 8,
    localparam int CNT_W          = $clog2(MAX_OUT_STORES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic              ld_nonidem_i,
    output logic              ld_gnt_o,
    input  logic              st_req_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_wdata_i,
    input  logic [BE_W-1:0]   st_be_i,
    output logic              st_gnt_o,
    input  logic              fence_i,
    output logic              fence_done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [BE_W-1:0]   mem_be_o,
    input  logic              mem_gnt_i,
    input  logic              mem_wack_i,
    output logic [CNT_W-1:0]  out_stores_o,
    output logic              wack_err_o
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    sched_state_e         state, state_next;
    port_sel_e            sel, lock_sel;
    mem_port_req_t        req, lock_req;
    logic [STARVE_W-1:0]  starve;
    logic                 starve_full;
    logic                 st_elig, ld_elig;
    logic                 at_limit, is_zero;
    logic                 fence_done;

    wt_store_credit_cnt #(
        .MAX_CNT(MAX_OUT_STORES),
        .CNT_W  (CNT_W)
    ) u_credit (
        .clk          (clk_i),
        .rst          (rst_i),
        .inc          (st_gnt_o),
        .dec          (mem_wack_i),
        .count        (out_stores_o),
        .at_limit     (at_limit),
        .is_zero      (is_zero),
        .underflow_err(wack_err_o)
    );

    assign starve_full = (starve == STARVE_W'(STARVE_LIMIT));

    // A presented-but-ungranted request owns the port; a pending fence blocks new selections in ARB.
    always_comb begin
        st_elig = st_req_i && !at_limit && (state != DRAIN_FENCE);
        ld_elig = ld_req_i && (!ld_nonidem_i || is_zero) && (state == ARB);
        sel     = SEL_NONE;
        if (rst_i) begin
            sel = SEL_NONE;
        end else if (lock_sel != SEL_NONE) begin
            sel = lock_sel;
        end else if ((state == ARB) && fence_i) begin
            sel = SEL_NONE;
        end else if (ld_elig && !(starve_full && st_elig)) begin
            sel = SEL_LD;
        end else if (st_elig) begin
            sel = SEL_ST;
        end
    end

    always_comb begin
        req = '0;
        if ((sel != SEL_NONE) && (lock_sel != SEL_NONE)) begin
            req = lock_req;
        end else if (sel == SEL_LD) begin
            req.addr = ld_addr_i;
        end else if (sel == SEL_ST) begin
            req.we    = 1'b1;
            req.addr  = st_addr_i;
            req.wdata = st_wdata_i;
            req.be    = st_be_i;
        end
    end

    assign mem_req_o    = (sel != SEL_NONE);
    assign mem_we_o     = req.we;
    assign mem_addr_o   = req.addr;
    assign mem_wdata_o  = req.wdata;
    assign mem_be_o     = req.be;
    assign ld_gnt_o     = mem_gnt_i && (sel == SEL_LD);
    assign st_gnt_o     = mem_gnt_i && (sel == SEL_ST);
    assign fence_done_o = fence_done && !rst_i;

    always_comb begin
        state_next = state;
        fence_done = 1'b0;
        case (state)
            ARB: begin
                if (lock_sel == SEL_NONE) begin
                    if (fence_i) begin
                        state_next = DRAIN_FENCE;
                    end else if (ld_req_i && ld_nonidem_i && !is_zero) begin
                        state_next = DRAIN_NI;
                    end
                end
            end
            DRAIN_NI: begin
                if (is_zero) begin
                    state_next = ARB;
                end
            end
            DRAIN_FENCE: begin
                if (is_zero) begin
                    fence_done = 1'b1;
                    state_next = FENCE_WAIT;
                end
            end
            FENCE_WAIT: begin
                if (!fence_i) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ARB;
            lock_sel <= SEL_NONE;
            lock_req <= '0;
            starve   <= '0;
        end else begin
            state <= state_next;
            if (sel != SEL_NONE) begin
                if (mem_gnt_i) begin
                    lock_sel <= SEL_NONE;
                end else begin
                    lock_sel <= sel;
                    lock_req <= req;
                end
            end
            // Starvation only accumulates while a store is actually waiting.
            if (st_gnt_o || !st_req_i) begin
                starve <= '0;
            end else if (ld_gnt_o && !starve_full) begin
                starve <= starve + 1'b1;
            end
        end
    end

endmodule
